// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: command opcodes, FSM states
// and fast-read dummy length.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_JEDEC_ID  = 8'h9F;

    localparam int DUMMY_CYCLES = 8;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        ID,
        IGNORE,
        DUMMY
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus a rise/fall detector on the
// synchronised spi_clk. Chip select resets to its inactive (high) level.
module spi_pin_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic i_csb,
    input  logic i_spi_clk,
    input  logic i_mosi,
    output logic o_csb,
    output logic o_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall
);

    logic r_csb_meta, r_csb_sync;
    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_mosi_meta, r_mosi_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a real shift chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_csb_meta  <= 1'b1;
            r_csb_sync  <= 1'b1;
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_csb_meta  <= i_csb;
            r_csb_sync  <= r_csb_meta;
            r_sclk_meta <= i_spi_clk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_mosi_meta <= i_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    assign o_csb       = r_csb_sync;
    assign o_mosi      = r_mosi_sync;
    assign o_sclk_rise =  r_sclk_sync & ~r_sclk_prev;
    assign o_sclk_fall = ~r_sclk_sync &  r_sclk_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI flash target serving READ (0x03) and JEDEC ID (0x9F) from a
// byte-wide synchronous memory; SPI_RESP_FAST_READ_EN adds FAST READ (0x0B).
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W   = 24,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              csb,
    input  logic              spi_clk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    logic w_csb, w_mosi, w_rise, w_fall;

    spi_pin_sync u_pin_sync (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_csb       (csb),
        .i_spi_clk   (spi_clk),
        .i_mosi      (mosi),
        .o_csb       (w_csb),
        .o_mosi      (w_mosi),
        .o_sclk_rise (w_rise),
        .o_sclk_fall (w_fall)
    );

    state_t            r_state, w_state_nxt;
    logic [4:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [23:0]       r_shift, w_shift_nxt;
    logic [7:0]        r_tx, w_tx_nxt;
    logic [7:0]        r_prefetch, w_prefetch_nxt;
    logic              r_miso, w_miso_nxt;
    logic              r_miso_oe, w_miso_oe_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_first, w_first_nxt;
    logic              r_rd_valid, w_rd_valid_nxt;
    logic [23:0]       w_shift_in;
    logic [7:0]        w_tx_cur, w_pf_cur;

`ifdef SPI_RESP_FAST_READ_EN
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYCLES - 1);
    logic r_fast, w_fast_nxt;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= '0;
            r_prefetch <= '0;
            r_miso     <= 1'b0;
            r_miso_oe  <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_first    <= 1'b0;
            r_rd_valid <= 1'b0;
`ifdef SPI_RESP_FAST_READ_EN
            r_fast     <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_prefetch <= w_prefetch_nxt;
            r_miso     <= w_miso_nxt;
            r_miso_oe  <= w_miso_oe_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_busy     <= w_busy_nxt;
            r_first    <= w_first_nxt;
            r_rd_valid <= w_rd_valid_nxt;
`ifdef SPI_RESP_FAST_READ_EN
            r_fast     <= w_fast_nxt;
`endif
        end
    end

    always_comb begin
        // NOTE: every signal written here is given a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_miso_nxt     = r_miso;
        w_miso_oe_nxt  = r_miso_oe;
        w_mem_req_nxt  = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_busy_nxt     = r_busy;
        w_first_nxt    = r_first;
        w_rd_valid_nxt = r_mem_req;
        w_shift_in     = {r_shift[22:0], w_mosi};
        w_tx_cur       = r_tx;
        w_pf_cur       = r_prefetch;
`ifdef SPI_RESP_FAST_READ_EN
        w_fast_nxt     = r_fast;
`endif

        // Memory returns land in tx for the first byte, in the prefetch buffer
        // afterwards; the bypass covers a falling edge in the return cycle.
        if (r_rd_valid) begin
            if (r_first) begin
                w_tx_cur    = mem_rdata;
                w_first_nxt = 1'b0;
            end else begin
                w_pf_cur = mem_rdata;
            end
        end
        w_tx_nxt       = w_tx_cur;
        w_prefetch_nxt = w_pf_cur;

        if (w_csb) begin
            w_state_nxt    = IDLE;
            w_bit_cnt_nxt  = '0;
            w_miso_nxt     = 1'b0;
            w_miso_oe_nxt  = 1'b0;
            w_busy_nxt     = 1'b0;
            w_first_nxt    = 1'b0;
            w_rd_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nxt   = CMD;
                    w_bit_cnt_nxt = '0;
                end
                CMD: if (w_rise) begin
                    w_shift_nxt = w_shift_in;
                    if (r_bit_cnt == 5'd7) begin
                        w_bit_cnt_nxt = '0;
                        w_busy_nxt    = 1'b1;
                        case (w_shift_in[7:0])
                            CMD_READ:     w_state_nxt = ADDR;
                            CMD_JEDEC_ID: begin
                                w_state_nxt = ID;
                                w_shift_nxt = JEDEC_ID;
                            end
`ifdef SPI_RESP_FAST_READ_EN
                            CMD_FAST_READ: begin
                                w_state_nxt = ADDR;
                                w_fast_nxt  = 1'b1;
                            end
`endif
                            default:      w_state_nxt = IGNORE;
                        endcase
`ifdef SPI_RESP_FAST_READ_EN
                        if (w_shift_in[7:0] != CMD_FAST_READ) w_fast_nxt = 1'b0;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end
                ADDR: if (w_rise) begin
                    w_shift_nxt = w_shift_in;
                    if (r_bit_cnt == 5'd23) begin
                        w_bit_cnt_nxt  = '0;
                        w_mem_addr_nxt = w_shift_in[ADDR_W-1:0];
                        w_mem_req_nxt  = 1'b1;
                        w_first_nxt    = 1'b1;
`ifdef SPI_RESP_FAST_READ_EN
                        w_state_nxt    = r_fast ? DUMMY : DATA;
`else
                        w_state_nxt    = DATA;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end
`ifdef SPI_RESP_FAST_READ_EN
                DUMMY: if (w_rise) begin
                    if (r_bit_cnt == DUMMY_LAST) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = DATA;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end
`endif
                DATA: if (w_fall) begin
                    w_miso_nxt    = w_tx_cur[7];
                    w_miso_oe_nxt = 1'b1;
                    if (r_bit_cnt == 5'd0) begin
                        w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
                        w_mem_req_nxt  = 1'b1;
                    end
                    if (r_bit_cnt == 5'd7) begin
                        w_tx_nxt      = w_pf_cur;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_tx_nxt      = {w_tx_cur[6:0], 1'b0};
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                    end
                end
                ID: if (w_fall) begin
                    w_miso_nxt    = r_shift[23];
                    w_shift_nxt   = {r_shift[22:0], 1'b0};
                    w_miso_oe_nxt = 1'b1;
                end
                IGNORE: w_miso_oe_nxt = 1'b0;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign miso     = r_miso;
    assign miso_oe  = r_miso_oe;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;
    assign busy     = r_busy;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed self-checking bench for spi_flash_responder: READ, address wrap,
// JEDEC ID, unknown command, aborts, async reset and (optional) FAST READ.
module tb_spi_flash_responder;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        csb;
    logic        spi_clk;
    logic        mosi;
    logic        miso;
    logic        miso_oe;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic        oe_and;
    logic        oe_or;
    logic [7:0]  rx;
    logic [23:0] req_q[$];

    spi_flash_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .csb       (csb),
        .spi_clk   (spi_clk),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] mem_val(input logic [23:0] a);
        case (a)
            24'h000000: return 8'hA5;
            24'h000001: return 8'h5A;
            24'h000002: return 8'h01;
            24'h000003: return 8'hFF;
            24'h000010: return 8'hC3;
            24'hFFFFFF: return 8'h7E;
            default:    return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    always @(posedge clock) if (mem_req) mem_rdata <= mem_val(mem_addr);

    always @(negedge clock) if (reset_n && mem_req) req_q.push_back(mem_addr);

    function automatic logic [31:0] get_req(input int i);
        if (req_q.size() > i) return {8'h00, req_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Shifts the top n bits of tx, MSB first; miso is sampled just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi = tx[i];
            #60;
            r = {r[6:0], miso};
            oe_and = oe_and & miso_oe;
            oe_or  = oe_or | miso_oe;
            spi_clk = 1'b1;
            #60;
            spi_clk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] r);
        spi_bits(tx, 8, r);
    endtask

    task automatic cs_begin();
        req_q.delete();
        csb = 1'b0;
        #60;
    endtask

    task automatic cs_end();
        #60;
        csb = 1'b1;
        #100;
    endtask

    task automatic send_read(input logic [7:0] cmd, input logic [23:0] a);
        spi_byte(cmd, rx);
        spi_byte(a[23:16], rx);
        spi_byte(a[15:8], rx);
        spi_byte(a[7:0], rx);
    endtask

    initial begin
        reset_n = 1'b0;
        csb     = 1'b1;
        spi_clk = 1'b0;
        mosi    = 1'b0;
        oe_and  = 1'b1;
        oe_or   = 1'b0;
        #20;
        check("rst_miso",    32'(miso),     32'h0);
        check("rst_oe",      32'(miso_oe),  32'h0);
        check("rst_req",     32'(mem_req),  32'h0);
        check("rst_addr",    32'(mem_addr), 32'h0);
        check("rst_busy",    32'(busy),     32'h0);
        reset_n = 1'b1;
        #100;

        // READ from 0: four bytes plus the sequential prefetch addresses
        cs_begin();
        send_read(8'h03, 24'h000000);
        check("rd0_busy", 32'(busy), 32'h1);
        spi_byte(8'h00, rx); check("rd0_b0", 32'(rx), 32'hA5);
        spi_byte(8'h00, rx); check("rd0_b1", 32'(rx), 32'h5A);
        spi_byte(8'h00, rx); check("rd0_b2", 32'(rx), 32'h01);
        spi_byte(8'h00, rx); check("rd0_b3", 32'(rx), 32'hFF);
        check("rd0_req0", get_req(0), 32'h000000);
        check("rd0_req1", get_req(1), 32'h000001);
        check("rd0_req2", get_req(2), 32'h000002);
        check("rd0_req3", get_req(3), 32'h000003);
        cs_end();
        check("rd0_end_busy", 32'(busy),    32'h0);
        check("rd0_end_oe",   32'(miso_oe), 32'h0);

        // READ at the top of the address space wraps to 0
        cs_begin();
        send_read(8'h03, 24'hFFFFFF);
        spi_byte(8'h00, rx); check("wrap_b0", 32'(rx), 32'h7E);
        spi_byte(8'h00, rx); check("wrap_b1", 32'(rx), 32'hA5);
        check("wrap_req0", get_req(0), 32'hFFFFFF);
        check("wrap_req1", get_req(1), 32'h000000);
        cs_end();

        // JEDEC ID then zeros, with miso_oe held through every ID bit
        cs_begin();
        spi_byte(8'h9F, rx);
        oe_and = 1'b1;
        spi_byte(8'h00, rx); check("id_b0", 32'(rx), 32'hEF);
        spi_byte(8'h00, rx); check("id_b1", 32'(rx), 32'h40);
        spi_byte(8'h00, rx); check("id_b2", 32'(rx), 32'h16);
        spi_byte(8'h00, rx); check("id_b3", 32'(rx), 32'h00);
        check("id_oe", 32'(oe_and), 32'h1);
        cs_end();

        // Unknown command: no drive, no memory traffic; next READ unaffected
        cs_begin();
        oe_or = 1'b0;
        spi_byte(8'h42, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'hFF, rx);
        check("unk_oe",  32'(oe_or),        32'h0);
        check("unk_req", 32'(req_q.size()), 32'h0);
        cs_end();
        cs_begin();
        send_read(8'h03, 24'h000002);
        spi_byte(8'h00, rx); check("unk_next_b0", 32'(rx), 32'h01);
        cs_end();

        // Abort after 12 address bits: no memory request
        cs_begin();
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        spi_bits(8'h00, 4, rx);
        cs_end();
        check("abort_req", 32'(req_q.size()), 32'h0);

        // Asynchronous reset in the middle of a data byte
        cs_begin();
        send_read(8'h03, 24'h000000);
        spi_byte(8'h00, rx);
        spi_bits(8'h00, 4, rx);
        check("mid_oe",   32'(miso_oe), 32'h1);
        check("mid_busy", 32'(busy),    32'h1);
        reset_n = 1'b0;
        #1;
        check("arst_miso", 32'(miso),     32'h0);
        check("arst_oe",   32'(miso_oe),  32'h0);
        check("arst_req",  32'(mem_req),  32'h0);
        check("arst_addr", 32'(mem_addr), 32'h0);
        check("arst_busy", 32'(busy),     32'h0);
        #9;
        csb = 1'b1;
        #100;
        reset_n = 1'b1;
        #100;

        // FAST READ: served with the feature, ignored without it
        cs_begin();
        oe_or = 1'b0;
        send_read(8'h0B, 24'h000010);
`ifdef SPI_RESP_FAST_READ_EN
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx); check("fast_b0", 32'(rx), 32'hC3);
        check("fast_req0", get_req(0), 32'h000010);
`else
        spi_byte(8'h00, rx);
        spi_byte(8'h00, rx);
        check("fast_off_oe",  32'(oe_or),        32'h0);
        check("fast_off_req", 32'(req_q.size()), 32'h0);
`endif
        cs_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
